vsfx_sub_seq: RTL and testbench
===============================

// Module: vsfx_sub_seq
// PURPOSE
//   Sequencer for the vector simple fixed-point modulo-subtract datapath.
//   Accepts one 32*NWORDS-bit vector subtract (vrt = vra - vrb) per transaction.
//   Feeds it through a single internal 32-bit lane-partitioned subtract slice,
//   one 32-bit word per cycle, and assembles the full result.
//   Sits between the vector issue stage and the VR writeback.
//   Valid/ready handshakes on both sides.
// PARAMETERS
//   NWORDS  4  number of 32-bit words per vector (vector width = 32*NWORDS)
// PORTS
//   clk        in   1          clock, rising edge
//   rst        in   1          synchronous reset, active-high
//   in_valid   in   1          issue request valid
//   in_ready   out  1          sequencer can accept a request
//   in_op      in   2          element size: 00 byte, 01 halfword, 10 word, 11 illegal
//   in_vra     in   32*NWORDS  minuend vector
//   in_vrb     in   32*NWORDS  subtrahend vector
//   out_valid  out  1          result valid
//   out_ready  in   1          writeback accepts result
//   out_vrt    out  32*NWORDS  result vector
//   out_err    out  1          result came from an illegal op (qualified by out_valid)
//   busy       out  1          high in RUN or DONE
// BEHAVIOUR
//   Reset: state=IDLE, in_ready=1, out_valid=0, out_vrt=0, out_err=0, busy=0, cnt=0.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1.
//     - On an edge with in_valid&&in_ready: latch op/vra/vrb, clear out_vrt, cnt=0, go to RUN.
//   - RUN: in_ready=0.
//     - Each edge writes slice result into out_vrt word[cnt] (bits 32*cnt+31 : 32*cnt).
//     - Then cnt++.
//     - After word NWORDS-1 is written: go to DONE; out_valid=1 from the next cycle.
//   - DONE: out_valid=1.
//     - out_vrt and out_err held stable until out_valid&&out_ready at an edge.
//     - On that edge: go to IDLE, out_valid=0. out_vrt holds its last value.
//   Latency: acceptance edge E0; words 0..NWORDS-1 written at E1..E_NWORDS.
//     - out_valid is seen high in the cycle after E_NWORDS (NWORDS=4: 4 edges after accept).
//   Throughput: no bypass. in_ready stays low in RUN/DONE and returns in the cycle after
//     the output handshake. Minimum NWORDS+2 cycles per transaction.
//   in_valid while busy: ignored. Requester must hold the request until in_ready.
//   out_ready while not out_valid: ignored. out_ready may be held high permanently.
//   Arithmetic per word, modulo 2^n per element; borrow never crosses an element boundary:
//     - op 00: four 8-bit lanes, r = (a + ~b + 1) mod 2^8
//     - op 01: two 16-bit lanes; op 10: one 32-bit lane
//     - op 11: word result 0; out_err=1 for the transaction (full sequence still runs)
//   Edge cases: a==b -> 0; 0x00-0x01 -> 0xFF per byte lane (wrap, no flag).
//   cnt wraps only through IDLE reload, never in place.
//   Reset mid-RUN/DONE: in-flight transaction discarded.
//     - All outputs return to reset values at that edge. No out_valid for the lost request.
//   Simultaneous rst with in_valid or out_ready: rst wins.
// TESTING
//   1 byte op: vra=0x00010203_FF000080_..., vrb=0x01010101_01010101_...
//       -> word0 lanes correct incl. 0x00-0x01=0xFF. No borrow into the next lane.
//   2 halfword/word ops: word0 a=0x00000000, b=0x00000001
//       -> op01 gives 0xFFFF_FFFF per halfword pair only where borrowed (0x0000FFFF).
//       -> op10 gives 0xFFFFFFFF.
//   3 latency/handshake: accept at E0, out_ready=1
//       -> out_valid high exactly cycle after E4 for 1 cycle; in_ready high next cycle.
//   4 backpressure: out_ready=0 for 10 cycles
//       -> out_valid, out_vrt, out_err stable. in_valid pulses ignored, in_ready=0.
//   5 illegal op 11 -> out_vrt=0, out_err=1; next legal op clears out_err.
//   6 rst asserted in RUN with cnt=2 -> next cycle IDLE, in_ready=1, out_valid=0, out_vrt=0.
//       No result is ever produced for the aborted request.

Source files
------------

// File: rtl/vsfx_sub_if.sv
// Issue-side and writeback-side handshake bundle for the vector subtract sequencer.
interface vsfx_sub_if #(
  parameter int NWORDS = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic [1:0]             in_op;
  logic [32*NWORDS-1:0]   in_vra;
  logic [32*NWORDS-1:0]   in_vrb;
  logic                   out_valid;
  logic                   out_ready;
  logic [32*NWORDS-1:0]   out_vrt;
  logic                   out_err;
  logic                   busy;

  modport master (
    output in_valid, in_op, in_vra, in_vrb, out_ready,
    input  in_ready, out_valid, out_vrt, out_err, busy
  );

  modport slave (
    input  in_valid, in_op, in_vra, in_vrb, out_ready,
    output in_ready, out_valid, out_vrt, out_err, busy
  );
endinterface

// File: rtl/vsfx_sub_seq.sv
// Vector modulo-subtract sequencer: one 32-bit lane-partitioned slice reused
// over NWORDS cycles, result assembled in place and held until writeback takes it.
//
// state | meaning
// IDLE  | ready for a request, last result still visible on out_vrt
// RUN   | slice processing word[cnt], one word per edge
// DONE  | full result valid, waiting for out_ready
module vsfx_sub_seq #(
  parameter int NWORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  vsfx_sub_if.slave   bus
);
  localparam int W  = 32 * NWORDS;
  localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q;
  logic [W-1:0]    vra_q, vrb_q, vrt_q;
  logic [CW-1:0]   cnt_q;
  logic            err_q;
  logic            accept, last_word, out_fire;
  logic [31:0]     word_a, word_b, word_r;

  // Borrows stay inside each element because every lane is its own subtract.
  function automatic logic [31:0] sub_word(input logic [1:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [31:0] r;
    r = '0;
    case (op)
      2'b00: for (int k = 0; k < 4; k++) r[8*k +: 8] = a[8*k +: 8] - b[8*k +: 8];
      2'b01: for (int k = 0; k < 2; k++) r[16*k +: 16] = a[16*k +: 16] - b[16*k +: 16];
      2'b10: r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign out_fire  = (state_q == DONE) && bus.out_ready;
  assign last_word = (cnt_q == CW'(NWORDS - 1));
  assign word_a    = vra_q[int'(cnt_q)*32 +: 32];
  assign word_b    = vrb_q[int'(cnt_q)*32 +: 32];
  assign word_r    = sub_word(op_q, word_a, word_b);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_fire)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      vra_q <= '0;
      vrb_q <= '0;
      vrt_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= bus.in_op;
          vra_q <= bus.in_vra;
          vrb_q <= bus.in_vrb;
          vrt_q <= '0;
          cnt_q <= '0;
          err_q <= (bus.in_op == 2'b11);
        end
        RUN: begin
          vrt_q[int'(cnt_q)*32 +: 32] <= word_r;
          // Hold at the last index; the counter only restarts on a new accept.
          if (!last_word) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_vrt   = vrt_q;
  assign bus.out_err   = err_q;
endmodule

// File: tb/tb_vsfx_sub_seq.sv
// Randomized bench for vsfx_sub_seq against an element-wise arithmetic reference.
module tb_vsfx_sub_seq;
  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  vsfx_sub_if #(.NWORDS(NW)) bus ();

  vsfx_sub_seq #(.NWORDS(NW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Element-wise modular difference computed with plain integer arithmetic.
  function automatic logic [W-1:0] ref_sub(input logic [1:0] op,
                                           input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0]    res, sa, sb;
    longint unsigned ea, eb, r, mask;
    int              esz;
    res = '0;
    if (op == 2'b11) return res;
    esz  = 8 << op;
    mask = (64'd1 << esz) - 1;
    for (int i = 0; i < W; i += esz) begin
      sa = a >> i;
      sb = b >> i;
      ea = longint'(sa[31:0]) & mask;
      eb = longint'(sb[31:0]) & mask;
      r  = (ea + (64'd1 << esz) - eb) & mask;
      res = res | (W'(r) << i);
    end
    return res;
  endfunction

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    for (int i = 0; i < NW; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_txn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit keep_rdy, output logic [W-1:0] res);
    logic [W-1:0] exp;
    int           st;
    exp = ref_sub(op, a, b);
    st  = keep_rdy ? 0 : stall;
    @(negedge clk);
    check("idle_rdy", bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_vra    = a;
    bus.in_vrb    = b;
    bus.out_ready = keep_rdy;
    @(posedge clk); #1;
    for (int k = 0; k < NW; k++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_op    = 2'($urandom_range(0, 3));
      bus.in_vra   = rand_vec();
      bus.in_vrb   = rand_vec();
      @(negedge clk);
      check("run_no_valid", bus.out_valid, 0);
      check("run_busy", bus.busy, 1);
      check("run_no_rdy", bus.in_ready, 0);
      @(posedge clk); #1;
    end
    for (int s = 0; s <= st; s++) begin
      bus.out_ready = (s == st) ? 1'b1 : 1'b0;
      bus.in_valid  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("done_valid", bus.out_valid, 1);
      check("done_vrt", bus.out_vrt, exp);
      check("done_err", bus.out_err, (op == 2'b11));
      check("done_no_rdy", bus.in_ready, 0);
      res = bus.out_vrt;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    check("post_no_valid", bus.out_valid, 0);
    check("post_rdy", bus.in_ready, 1);
    check("post_idle", bus.busy, 0);
    check("post_vrt_held", bus.out_vrt, exp);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, bus.in_ready, 1);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_vrt"}, bus.out_vrt, '0);
    check({tag, "_err"}, bus.out_err, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic quiet_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("abort_no_valid", bus.out_valid, 0);
    end
  endtask

  logic [W-1:0] a, b, r;
  logic [1:0]   op;

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_vra    = '0;
    bus.in_vrb    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");

    // byte lanes, including 0x00-0x01 wrap with no borrow into the next lane
    a = 128'hDEADBEEF_12345678_FF000080_00010203;
    b = {NW{32'h01010101}};
    do_txn(2'b00, a, b, 0, 1'b0, r);
    check("byte_word0", r[31:0], 32'hFF000102);
    check("byte_word1", r[63:32], 32'hFEFFFF7F);

    a = '0;
    b = {{(W-32){1'b0}}, 32'h00000001};
    do_txn(2'b01, a, b, 0, 1'b1, r);
    check("half_word0", r[31:0], 32'h0000FFFF);
    do_txn(2'b10, a, b, 0, 1'b0, r);
    check("word_word0", r[31:0], 32'hFFFFFFFF);

    a = rand_vec();
    do_txn(2'b10, a, a, 0, 1'b0, r);
    check("equal_zero", r, '0);

    // long backpressure with ignored issue pulses
    do_txn(2'b00, rand_vec(), rand_vec(), 10, 1'b0, r);

    do_txn(2'b11, rand_vec(), rand_vec(), 2, 1'b0, r);
    check("illegal_zero", r, '0);
    do_txn(2'b01, rand_vec(), rand_vec(), 0, 1'b0, r);
    check("err_cleared", bus.out_err, 0);

    for (int t = 0; t < 24; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = rand_vec();
      b  = ($urandom_range(0, 4) == 0) ? a : rand_vec();
      do_txn(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)), r);
    end

    // reset while in RUN with cnt=2, issue request asserted at the reset edge
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b10;
    bus.in_vra   = rand_vec() | 128'h1;
    bus.in_vrb   = '0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_reset_vals("abort_run");
    quiet_cycles(8);

    // reset while DONE with out_ready asserted at the same edge
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b11;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (NW) @(posedge clk);
    @(negedge clk);
    check("pre_abort_valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check_reset_vals("abort_done");
    quiet_cycles(6);

    do_txn(2'b00, rand_vec(), rand_vec(), 1, 1'b0, r);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
